// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared fetch-stage types and constants for the MIPS pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    // Sequential fetch advance; wraps naturally at the top of the address space
    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Circular queue of fetched entries with clear and keep-second.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type ENTRY_T = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_clear,
    input  logic                   i_keep_second,
    input  ENTRY_T                 i_entry,
    output ENTRY_T                 o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    ENTRY_T        r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Clear and keep-second take priority over ordinary push/pop traffic
    always_ff @(posedge clk) begin
        if (w_do_push && !i_clear && !i_keep_second) begin
            r_mem[r_tail] <= i_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_keep_second) begin
            r_head  <= r_head + PW'(1);
            r_tail  <= r_head + PW'(1) + PW'(1);
            r_count <= CW'(1);
        end else begin
            if (w_do_push) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_do_pop) begin
                r_head <= r_head + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_head];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/if_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : if_prefetch_queue
// Description : Fetch PC generation, prefetch queue and redirect/flush control.
// Revision    : 1.0 - initial release
// ============================================================================
module if_prefetch_queue
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          DEPTH      = 4,
    parameter int          DELAY_SLOT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [31:0]            imem_addr,
    input  logic [31:0]            imem_rdata,
    output logic                   id_valid,
    input  logic                   id_ready,
    output logic [31:0]            id_pc,
    output logic [31:0]            id_instr,
    output logic                   id_adel,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    input  logic                   flush,
    input  logic [31:0]            flush_pc,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int         CW      = $clog2(DEPTH) + 1;
    localparam bit         C_DS    = (DELAY_SLOT != 0);
    localparam logic [0:0] ST_RUN  = RUN;
    localparam logic [0:0] ST_HALT = HALT;

    logic [0:0]    r_state;
    logic [31:0]   r_fetch_pc;

    fetch_entry_t  w_entry;
    fetch_entry_t  w_head;
    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    logic          w_hs;
    logic          w_fetch;
    logic          w_misaligned;
    logic          w_redirect;
    logic          w_clear;
    logic          w_keep;
    logic          w_push;
    logic          w_pop;

    assign w_hs         = !w_empty && id_ready;
    assign w_fetch      = (r_state == ST_RUN) && !w_full;
    assign w_misaligned = (r_fetch_pc[1:0] != 2'b00);
    assign w_redirect   = w_hs && redirect && !flush;

    always_comb begin
        w_entry.pc    = r_fetch_pc;
        w_entry.instr = w_misaligned ? 32'd0 : imem_rdata;
        w_entry.adel  = w_misaligned;
    end

    // With a delay slot and more than the head queued, only head+1 survives;
    // with only the head queued, the word fetched this cycle becomes the slot.
    assign w_clear = flush || (w_redirect && !C_DS);
    assign w_keep  = !flush && w_redirect && C_DS && (w_count >= CW'(2));
    assign w_push  = w_fetch && !w_clear && !w_keep;
    assign w_pop   = w_hs && !flush;

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_T (fetch_entry_t)
    ) u_fifo (
        .clk           (clk),
        .rst           (rst),
        .i_push        (w_push),
        .i_pop         (w_pop),
        .i_clear       (w_clear),
        .i_keep_second (w_keep),
        .i_entry       (w_entry),
        .o_head        (w_head),
        .o_count       (w_count),
        .o_full        (w_full),
        .o_empty       (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_state    <= ST_RUN;
        end else if (flush) begin
            r_fetch_pc <= flush_pc;
            r_state    <= ST_RUN;
        end else if (w_redirect) begin
            r_fetch_pc <= redirect_pc;
            r_state    <= ST_RUN;
        end else if (w_fetch) begin
            if (w_misaligned) begin
                r_state <= ST_HALT;
            end else begin
                r_fetch_pc <= next_seq_pc(r_fetch_pc);
            end
        end
    end

    assign imem_addr = r_fetch_pc;
    assign id_valid  = !w_empty;
    assign id_pc     = w_empty ? 32'd0 : w_head.pc;
    assign id_instr  = w_empty ? 32'd0 : w_head.instr;
    assign id_adel   = !w_empty && w_head.adel;
    assign occupancy = w_count;

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_prefetch_queue
// Description : Directed self-checking bench; DELAY_SLOT=1 and =0 side by side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_prefetch_queue;

    logic        clk = 1'b0;
    logic        r_rst;
    logic        r_ready;
    logic        r_redir;
    logic [31:0] r_redir_pc;
    logic        r_flush;
    logic [31:0] r_flush_pc;

    logic [31:0] w_addr1, w_rdata1, w_pc1, w_instr1;
    logic        w_valid1, w_adel1;
    logic [2:0]  w_occ1;
    logic [31:0] w_addr0, w_rdata0, w_pc0, w_instr0;
    logic        w_valid0, w_adel0;
    logic [2:0]  w_occ0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    assign w_rdata1 = imem_word(w_addr1);
    assign w_rdata0 = imem_word(w_addr0);

    if_prefetch_queue #(.RESET_PC(32'h3000), .DEPTH(4), .DELAY_SLOT(1)) u_dut_ds1 (
        .clk(clk), .rst(r_rst), .imem_addr(w_addr1), .imem_rdata(w_rdata1),
        .id_valid(w_valid1), .id_ready(r_ready), .id_pc(w_pc1), .id_instr(w_instr1),
        .id_adel(w_adel1), .redirect(r_redir), .redirect_pc(r_redir_pc),
        .flush(r_flush), .flush_pc(r_flush_pc), .occupancy(w_occ1)
    );

    if_prefetch_queue #(.RESET_PC(32'h3000), .DEPTH(4), .DELAY_SLOT(0)) u_dut_ds0 (
        .clk(clk), .rst(r_rst), .imem_addr(w_addr0), .imem_rdata(w_rdata0),
        .id_valid(w_valid0), .id_ready(r_ready), .id_pc(w_pc0), .id_instr(w_instr0),
        .id_adel(w_adel0), .redirect(r_redir), .redirect_pc(r_redir_pc),
        .flush(r_flush), .flush_pc(r_flush_pc), .occupancy(w_occ0)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        r_rst   = 1'b1;
        r_ready = 1'b0;
        r_redir = 1'b0;
        r_flush = 1'b0;
        step();
        r_rst   = 1'b0;
    endtask

    initial begin
        r_rst = 1'b1; r_ready = 1'b0; r_redir = 1'b0; r_redir_pc = '0;
        r_flush = 1'b0; r_flush_pc = '0;

        // 1: reset values, then back-to-back streaming
        step(); step();
        check_eq("rst_valid", {31'd0, w_valid1}, 32'd0);
        check_eq("rst_occ",   {29'd0, w_occ1},   32'd0);
        check_eq("rst_pc",    w_pc1,             32'd0);
        check_eq("rst_instr", w_instr1,          32'd0);
        check_eq("rst_adel",  {31'd0, w_adel1},  32'd0);
        check_eq("rst_addr",  w_addr1,           32'h3000);
        r_rst = 1'b0; r_ready = 1'b1;
        step();
        check_eq("t1_valid0", {31'd0, w_valid1}, 32'd1);
        check_eq("t1_pc0",    w_pc1,             32'h3000);
        check_eq("t1_instr0", w_instr1,          32'hA5A5_3000);
        check_eq("t1_occ0",   {29'd0, w_occ1},   32'd1);
        step();
        check_eq("t1_pc1",    w_pc1,             32'h3004);
        check_eq("t1_occ1",   {29'd0, w_occ1},   32'd1);
        step();
        check_eq("t1_pc2",    w_pc1,             32'h3008);
        check_eq("t1_instr2", w_instr1,          32'hA5A5_3008);

        // 2: stall until full, then in-order drain
        do_reset();
        step(); step();
        check_eq("t2_occ2", {29'd0, w_occ1}, 32'd2);
        step(); step(); step(); step();
        check_eq("t2_occ_full", {29'd0, w_occ1}, 32'd4);
        check_eq("t2_addr_hold", w_addr1, 32'h3010);
        check_eq("t2_head", w_pc1, 32'h3000);
        r_ready = 1'b1;
        step();
        check_eq("t2_drain1", w_pc1, 32'h3004);
        check_eq("t2_occ_after_pop", {29'd0, w_occ1}, 32'd3);
        step();
        check_eq("t2_drain2", w_pc1, 32'h3008);
        step();
        check_eq("t2_drain3", w_pc1, 32'h300C);
        step();
        check_eq("t2_drain4", w_pc1, 32'h3010);

        // 3a: redirect while full
        do_reset();
        step(); step(); step(); step(); step();
        check_eq("t3a_full", {29'd0, w_occ1}, 32'd4);
        r_ready = 1'b1; r_redir = 1'b1; r_redir_pc = 32'h4000;
        step();
        r_redir = 1'b0;
        check_eq("t3a_ds1_slot", w_pc1, 32'h3004);
        check_eq("t3a_ds1_occ",  {29'd0, w_occ1}, 32'd1);
        check_eq("t3a_ds0_valid", {31'd0, w_valid0}, 32'd0);
        check_eq("t3a_ds0_addr", w_addr0, 32'h4000);
        step();
        check_eq("t3a_ds1_tgt", w_pc1, 32'h4000);
        check_eq("t3a_ds0_tgt", w_pc0, 32'h4000);
        step();
        check_eq("t3a_ds1_tgt4", w_pc1, 32'h4004);
        check_eq("t3a_ds0_tgt4", w_pc0, 32'h4004);

        // 3b: redirect with a single queued entry
        do_reset();
        r_ready = 1'b1;
        step();
        r_redir = 1'b1; r_redir_pc = 32'h4000;
        step();
        r_redir = 1'b0;
        check_eq("t3b_ds1_slot", w_pc1, 32'h3004);
        check_eq("t3b_ds1_occ", {29'd0, w_occ1}, 32'd1);
        check_eq("t3b_ds0_valid", {31'd0, w_valid0}, 32'd0);
        step();
        check_eq("t3b_ds1_tgt", w_pc1, 32'h4000);
        check_eq("t3b_ds0_tgt", w_pc0, 32'h4000);

        // 4: flush beats a same-cycle redirect
        do_reset();
        step(); step(); step(); step(); step();
        r_flush = 1'b1; r_flush_pc = 32'h4180;
        r_redir = 1'b1; r_redir_pc = 32'h5000; r_ready = 1'b1;
        step();
        r_flush = 1'b0; r_redir = 1'b0;
        check_eq("t4_valid", {31'd0, w_valid1}, 32'd0);
        check_eq("t4_occ",   {29'd0, w_occ1},   32'd0);
        check_eq("t4_addr",  w_addr1,           32'h4180);
        step();
        check_eq("t4_pc0", w_pc1, 32'h4180);
        step();
        check_eq("t4_pc1", w_pc1, 32'h4184);
        check_eq("t4_addr1", w_addr1, 32'h4188);

        // 5: misaligned redirect target raises AdEL and halts fetch
        r_redir = 1'b1; r_redir_pc = 32'h5002;
        step();
        r_redir = 1'b0;
        check_eq("t5_slot", w_pc1, 32'h4188);
        step();
        check_eq("t5_adel_pc", w_pc1, 32'h5002);
        check_eq("t5_adel", {31'd0, w_adel1}, 32'd1);
        check_eq("t5_adel_instr", w_instr1, 32'd0);
        r_ready = 1'b0;
        step(); step(); step();
        check_eq("t5_halt_occ", {29'd0, w_occ1}, 32'd1);
        check_eq("t5_halt_addr", w_addr1, 32'h5002);
        r_flush = 1'b1; r_flush_pc = 32'h4180;
        step();
        r_flush = 1'b0;
        check_eq("t5_flush_occ", {29'd0, w_occ1}, 32'd0);
        step();
        check_eq("t5_resume_pc", w_pc1, 32'h4180);
        check_eq("t5_resume_adel", {31'd0, w_adel1}, 32'd0);

        // fetch PC wraps at the top of the address space
        r_ready = 1'b1; r_flush = 1'b1; r_flush_pc = 32'hFFFF_FFF8;
        step();
        r_flush = 1'b0;
        step();
        check_eq("wrap_pc0", w_pc1, 32'hFFFF_FFF8);
        step();
        check_eq("wrap_pc1", w_pc1, 32'hFFFF_FFFC);
        step();
        check_eq("wrap_valid", {31'd0, w_valid1}, 32'd1);
        check_eq("wrap_pc2", w_pc1, 32'h0000_0000);
        check_eq("wrap_addr", w_addr1, 32'h0000_0004);

        // 6a: reset while full
        r_ready = 1'b0;
        step(); step(); step(); step();
        check_eq("t6_full", {29'd0, w_occ1}, 32'd4);
        r_rst = 1'b1;
        step();
        check_eq("t6_full_valid", {31'd0, w_valid1}, 32'd0);
        check_eq("t6_full_occ", {29'd0, w_occ1}, 32'd0);
        check_eq("t6_full_addr", w_addr1, 32'h3000);
        r_rst = 1'b0; r_ready = 1'b1;
        step();
        check_eq("t6_full_restart", w_pc1, 32'h3000);

        // 6b: reset while halted
        r_flush = 1'b1; r_flush_pc = 32'h6001;
        step();
        r_flush = 1'b0; r_ready = 1'b0;
        step();
        check_eq("t6_halt_adel", {31'd0, w_adel1}, 32'd1);
        step();
        check_eq("t6_halt_occ", {29'd0, w_occ1}, 32'd1);
        r_rst = 1'b1;
        step();
        check_eq("t6_halt_valid", {31'd0, w_valid1}, 32'd0);
        check_eq("t6_halt_occ0", {29'd0, w_occ1}, 32'd0);
        check_eq("t6_halt_addr", w_addr1, 32'h3000);
        r_rst = 1'b0;
        step();
        check_eq("t6_halt_restart", w_pc1, 32'h3000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
